// File: rtl/writeback_sequencer.sv
// -----------------------------------------------------------------------------
// writeback_sequencer
//   Serialises Y86-64 writeback onto a single register-file write port.
//   Each accepted instruction becomes zero, one or two writes. The E write
//   always goes before the M write, so popq %rsp leaves valM in the register.
//   Halt and invalid-instruction status are sticky until reset.
//
// Optional feature (compile-time macro):
//   WB_MERGE_SAME_DST_EN - when dstE == dstM the E write is skipped and only
//                          the M write (valM) issues. Final register state is
//                          the same either way.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_in_valid/o_in_ready instruction handshake
//   i_icode,i_rA,i_rB     instruction code and register operands
//   i_valE,i_valM,i_cond  ALU result, memory data, cmov condition
//   o_wr_en/addr/data     register-file write port
//   o_stat                0 AOK, 1 HLT, 2 INS (sticky)
//   o_done                pulses when an instruction's last write/slot issues
// -----------------------------------------------------------------------------
module writeback_sequencer #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_icode,
  input  logic [REG_W-1:0]  i_rA,
  input  logic [REG_W-1:0]  i_rB,
  input  logic [DATA_W-1:0] i_valE,
  input  logic [DATA_W-1:0] i_valM,
  input  logic              i_cond,
  output logic              o_wr_en,
  output logic [REG_W-1:0]  o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [1:0]        o_stat,
  output logic              o_done
);

  localparam logic [REG_W-1:0] RNONE = '1;
  localparam logic [REG_W-1:0] RSP   = REG_W'(4);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_E  = 3'd1,
    WR_M  = 3'd2,
    NOP_S = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t              r_state, w_next, w_acc_state;
  logic [REG_W-1:0]    r_dstE, r_dstM;
  logic [DATA_W-1:0]   r_valE, r_valM;
  logic [1:0]          r_stat, w_acc_stat;
  logic [REG_W-1:0]    w_dstE, w_dstM;
  logic                w_m_pend, w_ready, w_accept;

  // Destination decode straight off the input bus; only used on accept.
  always_comb begin
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (i_icode)
      4'h2:             if (i_cond) w_dstE = i_rB;
      4'h3, 4'h6:       w_dstE = i_rB;
      4'h8, 4'h9, 4'hA: w_dstE = RSP;
      4'hB: begin
        w_dstE = RSP;
        w_dstM = i_rA;
      end
      4'h5:             w_dstM = i_rA;
      default: ;
    endcase
  end

  // State an instruction enters on its accept edge, and its status effect.
  always_comb begin
    w_acc_state = NOP_S;
    w_acc_stat  = r_stat;
    if (i_icode == 4'h0) begin
      w_acc_state = STOP;
      w_acc_stat  = STAT_HLT;
    end else if (i_icode >= 4'hC) begin
      w_acc_state = STOP;
      w_acc_stat  = STAT_INS;
    end else if (w_dstE != RNONE) begin
`ifdef WB_MERGE_SAME_DST_EN
      // Same destination: the E value would be overwritten anyway.
      w_acc_state = (w_dstE == w_dstM) ? WR_M : WR_E;
`else
      w_acc_state = WR_E;
`endif
    end else if (w_dstM != RNONE) begin
      w_acc_state = WR_M;
    end
  end

  assign w_m_pend = (r_dstM != RNONE);

  // A pending M write blocks acceptance so the two writes stay back to back.
  always_comb begin
    case (r_state)
      IDLE, WR_M, NOP_S: w_ready = 1'b1;
      WR_E:              w_ready = !w_m_pend;
      default:           w_ready = 1'b0;
    endcase
  end

  assign w_accept   = i_in_valid && w_ready;
  assign o_in_ready = w_ready;
  assign o_stat     = r_stat;

  // State register plus latched instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_valE  <= '0;
      r_valM  <= '0;
      r_stat  <= STAT_AOK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dstE <= w_dstE;
        r_dstM <= w_dstM;
        r_valE <= i_valE;
        r_valM <= i_valM;
        r_stat <= w_acc_stat;
      end
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    w_next    = r_state;
    o_wr_en   = 1'b0;
    o_wr_addr = RNONE;
    o_wr_data = '0;
    o_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_accept ? w_acc_state : IDLE;
      end
      WR_E: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_dstE;
        o_wr_data = r_valE;
        if (w_m_pend) begin
          w_next = WR_M;
        end else begin
          o_done = 1'b1;
          w_next = w_accept ? w_acc_state : IDLE;
        end
      end
      WR_M: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_dstM;
        o_wr_data = r_valM;
        o_done    = 1'b1;
        w_next    = w_accept ? w_acc_state : IDLE;
      end
      NOP_S: begin
        o_done = 1'b1;
        w_next = w_accept ? w_acc_state : IDLE;
      end
      STOP: begin
        w_next = STOP;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_writeback_sequencer
//   Directed vectors with hand-computed expectations for writeback_sequencer.
//   Inputs are driven 1 time unit after the rising edge; outputs are checked
//   at the same point, i.e. they reflect the state entered on that edge.
// -----------------------------------------------------------------------------
module tb_writeback_sequencer;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  icode, rA, rB;
  logic [63:0] valE, valM;
  logic        cond;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  stat;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  // Shadow register file built from the write port, plus r4 write count.
  logic [63:0] rf [16];
  int          r4_writes = 0;

  writeback_sequencer #(.DATA_W(64), .REG_W(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_icode    (icode),
    .i_rA       (rA),
    .i_rB       (rB),
    .i_valE     (valE),
    .i_valM     (valM),
    .i_cond     (cond),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_stat     (stat),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      rf[wr_addr] = wr_data;
      if (wr_addr == 4'd4) r4_writes = r4_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm, input logic c);
    in_valid = 1'b1;
    icode    = ic;
    rA       = ra;
    rB       = rb;
    valE     = ve;
    valM     = vm;
    cond     = c;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    icode    = 4'h1;
    rA       = 4'hF;
    rB       = 4'hF;
    valE     = '0;
    valM     = '0;
    cond     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rst_n = 1'b0;
    idle_in();

    // Reset state
    #12;
    chk("rst_wr_en",   wr_en,    0);
    chk("rst_wr_addr", wr_addr,  4'hF);
    chk("rst_wr_data", wr_data,  0);
    chk("rst_stat",    stat,     0);
    chk("rst_done",    done,     0);
    chk("rst_ready",   in_ready, 1);
    #10 rst_n = 1'b1;

    // cmovxx, cond=0: no write, done slot
    drive(4'h2, 4'h4, 4'h3, 64'h1111, 64'h0, 1'b0);
    tick(); idle_in();
    chk("cmov0_wr_en", wr_en,    0);
    chk("cmov0_done",  done,     1);
    chk("cmov0_stat",  stat,     0);
    chk("cmov0_ready", in_ready, 1);
    tick();
    chk("cmov0_done_end", done, 0);

    // cmovxx, cond=1: write rB
    drive(4'h2, 4'hF, 4'h6, 64'h834020347D9347FF, 64'h0, 1'b1);
    tick(); idle_in();
    chk("cmov1_wr_en", wr_en,   1);
    chk("cmov1_addr",  wr_addr, 4'h6);
    chk("cmov1_data",  wr_data, 64'h834020347D9347FF);
    chk("cmov1_done",  done,    1);

    // popq rA=1: rsp<-valE, then r1<-valM
    drive(4'hB, 4'h1, 4'hF, 64'h10139371237D719B, 64'h9876543210FEDCB7, 1'b0);
    tick(); idle_in();
    chk("popq_e_wr_en", wr_en,    1);
    chk("popq_e_addr",  wr_addr,  4'h4);
    chk("popq_e_data",  wr_data,  64'h10139371237D719B);
    chk("popq_e_ready", in_ready, 0);
    chk("popq_e_done",  done,     0);
    tick();
    chk("popq_m_wr_en", wr_en,    1);
    chk("popq_m_addr",  wr_addr,  4'h1);
    chk("popq_m_data",  wr_data,  64'h9876543210FEDCB7);
    chk("popq_m_done",  done,     1);
    chk("popq_m_ready", in_ready, 1);
    tick();
    chk("popq_idle_wr_en", wr_en, 0);

    // irmovq r0 back-to-back with mrmovq r10, in_valid held high
    drive(4'h3, 4'hF, 4'h0, 64'hAAAA_0000_1234_5678, 64'h0, 1'b0);
    tick();
    drive(4'h5, 4'hA, 4'h2, 64'h0, 64'h5555_FFFF_8765_4321, 1'b0);
    chk("b2b_1_addr",  wr_addr,  4'h0);
    chk("b2b_1_data",  wr_data,  64'hAAAA_0000_1234_5678);
    chk("b2b_1_ready", in_ready, 1);
    chk("b2b_1_done",  done,     1);
    tick(); idle_in();
    chk("b2b_2_wr_en", wr_en,    1);
    chk("b2b_2_addr",  wr_addr,  4'hA);
    chk("b2b_2_data",  wr_data,  64'h5555_FFFF_8765_4321);
    chk("b2b_2_ready", in_ready, 1);
    chk("b2b_2_done",  done,     1);
    tick();
    chk("b2b_idle_wr_en", wr_en, 0);

    // popq %rsp: final r4 must be valM in both build flavours
    r4_writes = 0;
    drive(4'hB, 4'h4, 4'hF, 64'hE4E4_E4E4_E4E4_E4E4, 64'h4D4D_4D4D_4D4D_4D4D, 1'b0);
    tick(); idle_in();
`ifdef WB_MERGE_SAME_DST_EN
    chk("poprsp_addr", wr_addr, 4'h4);
    chk("poprsp_data", wr_data, 64'h4D4D_4D4D_4D4D_4D4D);
    chk("poprsp_done", done,    1);
    tick();
    chk("poprsp_idle", wr_en,   0);
    chk("poprsp_nwr",  r4_writes, 1);
`else
    chk("poprsp_e_addr", wr_addr, 4'h4);
    chk("poprsp_e_data", wr_data, 64'hE4E4_E4E4_E4E4_E4E4);
    chk("poprsp_e_done", done,    0);
    tick();
    chk("poprsp_m_addr", wr_addr, 4'h4);
    chk("poprsp_m_data", wr_data, 64'h4D4D_4D4D_4D4D_4D4D);
    chk("poprsp_m_done", done,    1);
    tick();
    chk("poprsp_idle",   wr_en,   0);
    chk("poprsp_nwr",    r4_writes, 2);
`endif
    chk("poprsp_r4", rf[4], 64'h4D4D_4D4D_4D4D_4D4D);

    // Reset in the WR_E cycle of a popq: M write is discarded
    rf[7] = '0;
    drive(4'hB, 4'h7, 4'hF, 64'h0101, 64'h0707, 1'b0);
    tick(); idle_in();
    chk("rstmid_e_wr_en", wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", wr_en,    0);
    chk("rstmid_addr",  wr_addr,  4'hF);
    chk("rstmid_data",  wr_data,  0);
    chk("rstmid_done",  done,     0);
    chk("rstmid_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    chk("rstmid_no_m", wr_en, 0);
    tick();
    chk("rstmid_r7", rf[7], 0);

    // halt: sticky stat=1, inputs ignored afterwards
    drive(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    tick();
    drive(4'h3, 4'hF, 4'h2, 64'h99, 64'h0, 1'b0);
    chk("hlt_stat",  stat,     1);
    chk("hlt_ready", in_ready, 0);
    chk("hlt_wr_en", wr_en,    0);
    chk("hlt_done",  done,     0);
    repeat (3) tick();
    chk("hlt_stat_hold",  stat,     1);
    chk("hlt_ready_hold", in_ready, 0);
    chk("hlt_wr_en_hold", wr_en,    0);
    idle_in();

    // Reset out of STOP, then nop / rmmovq slots, then invalid icode
    rst_n = 1'b0;
    #5 rst_n = 1'b1;
    chk("stop_rst_stat", stat, 0);
    drive(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
    tick();
    drive(4'h4, 4'h1, 4'h2, 64'h77, 64'h0, 1'b0);
    chk("nop_done",  done,  1);
    chk("nop_wr_en", wr_en, 0);
    tick();
    drive(4'hE, 4'h1, 4'h2, 64'h0, 64'h0, 1'b0);
    chk("rmmov_done",  done,  1);
    chk("rmmov_wr_en", wr_en, 0);
    tick(); idle_in();
    chk("ins_stat",  stat,     2);
    chk("ins_ready", in_ready, 0);
    chk("ins_wr_en", wr_en,    0);
    chk("ins_done",  done,     0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
